// File: rtl/fp32_row_max_sub.sv
// Row max-subtract stage ahead of the FP32 exp unit: buffers one score row, tracks its
// maximum, then streams x[i] - max through a shared multi-cycle FP32 adder.
module fp_adder_driver_ba #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] z
);
    logic [31:0] a_p0, b_p0;
    logic [3:0]  cnt;

    // IEEE-754 binary32 add, round-to-nearest-even, subnormals supported.
    function automatic logic [31:0] fp_add(input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] x, y;
        logic [7:0]  ex, ey, d;
        logic [26:0] lg, sf, sm;
        logic [27:0] s;
        logic [9:0]  e;
        logic [24:0] m;
        logic        a_nan, b_nan, a_inf, b_inf;
        a_nan = (fa[30:23] == 8'hFF) && (fa[22:0] != 23'd0);
        b_nan = (fb[30:23] == 8'hFF) && (fb[22:0] != 23'd0);
        a_inf = (fa[30:23] == 8'hFF) && (fa[22:0] == 23'd0);
        b_inf = (fb[30:23] == 8'hFF) && (fb[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (fa[31] != fb[31]))) return 32'h7FC0_0000;
        if (a_inf) return fa;
        if (b_inf) return fb;
        if (fa[30:0] >= fb[30:0]) begin x = fa; y = fb; end
        else                      begin x = fb; y = fa; end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        lg = {x[30:23] != 8'd0, x[22:0], 3'b000};
        sf = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = ex - ey;
        if (d >= 8'd27) sm = {26'd0, |sf};
        else            sm = (sf >> d) | {26'd0, |(sf & ((27'd1 << d) - 27'd1))};
        s = (x[31] == y[31]) ? ({1'b0, lg} + {1'b0, sm}) : ({1'b0, lg} - {1'b0, sm});
        // Exact cancellation gives +0 unless both operands were -0.
        if (s == 28'd0) return {x[31] & y[31], 31'd0};
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && (e > 10'd1)) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end
        m = {1'b0, s[26:3]};
        if (s[2] && (s[1] | s[0] | s[3])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], m[23] ? e[7:0] : 8'h00, m[22:0]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= 4'd0;
            a_p0 <= 32'd0;
            b_p0 <= 32'd0;
            z    <= 32'd0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    cnt  <= 4'd0;
                    a_p0 <= a;
                    b_p0 <= b;
                end
            end else if (cnt == 4'(LAT - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
                z    <= fp_add(a_p0, b_p0);
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module fp32_row_max_sub #(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp32,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_fp32,
    output logic        out_last,
    output logic        row_overflow
);
    typedef enum logic [1:0] {S_LOAD, S_SUB_ISSUE, S_SUB_WAIT, S_OUT} state_t;

    state_t             state, state_nx;
    logic [31:0]        row_buf [MAX_LEN];
    logic [IDX_W-1:0]   wr_cnt, rd_cnt, last_idx;
    logic               first;
    logic [31:0]        max_val;
    logic               add_start, add_busy, add_done;
    logic [31:0]        add_a, add_b, add_z;
    logic               accept, row_end, out_hs;

    // Sign-magnitude ordering; zeros compare equal and NaN never wins.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan) return 1'b0;
        if (b_nan) return 1'b1;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    assign accept  = in_valid && in_ready;
    assign row_end = accept && (in_last || (wr_cnt == IDX_W'(MAX_LEN - 1)));
    assign out_hs  = out_valid && out_ready;

    fp_adder_driver_ba u_add (
        .clk   (clk),
        .rst   (~rst_n),
        .start (add_start),
        .a     (add_a),
        .b     (add_b),
        .busy  (add_busy),
        .done  (add_done),
        .z     (add_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:      if (row_end) state_nx = S_SUB_ISSUE;
            S_SUB_ISSUE: if (add_start && add_busy) state_nx = S_SUB_WAIT;
            S_SUB_WAIT:  if (add_done) state_nx = S_OUT;
            S_OUT:       if (out_hs) state_nx = out_last ? S_LOAD : S_SUB_ISSUE;
            default:     state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) row_buf[wr_cnt] <= in_fp32;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b0;
            row_overflow <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            last_idx     <= '0;
            first        <= 1'b1;
            max_val      <= 32'd0;
            add_start    <= 1'b0;
            add_a        <= 32'd0;
            add_b        <= 32'd0;
            out_valid    <= 1'b0;
            out_fp32     <= 32'd0;
            out_last     <= 1'b0;
        end else begin
            // Staying in S_LOAD for two consecutive cycles guarantees an idle cycle after a row.
            in_ready     <= (state == S_LOAD) && (state_nx == S_LOAD);
            row_overflow <= row_end && !in_last;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        first  <= 1'b0;
                        if (first || fp_gt(in_fp32, max_val)) max_val <= in_fp32;
                        if (row_end) last_idx <= wr_cnt;
                    end
                end
                S_SUB_ISSUE: begin
                    if (!add_start && !add_busy) begin
                        add_start <= 1'b1;
                        add_a     <= row_buf[rd_cnt];
                        add_b     <= {~max_val[31], max_val[30:0]};
                    end else if (add_start && add_busy) begin
                        add_start <= 1'b0;
                    end
                end
                S_SUB_WAIT: begin
                    if (add_done) begin
                        out_fp32  <= add_z;
                        out_last  <= (rd_cnt == last_idx);
                        out_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                            first  <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fp32_row_max_sub.md
Name: fp32_row_max_sub

Overview:
- Upstream stage of the FP32 exponential unit in the attention-score softmax path.
- Accepts one row of FP32 attention scores, buffers it, and finds the row maximum.
- Then emits x[i] − max for each element, in input order, so the exp stage only sees non-positive arguments.
- Subtraction uses one shared fp_adder_driver_ba instance. The max search uses a combinational FP32 magnitude/sign compare.

Parameters:
- MAX_LEN, 64, maximum row length in elements (buffer depth). Must be ≥ 2.
- IDX_W, $clog2(MAX_LEN), width of the element index and counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  block can accept an input element this cycle.
- in_fp32  input  32  FP32 score.
- in_last  input  1  marks the final element of the row.
- out_valid  output  1  out_fp32 holds a valid x−max.
- out_ready  input  1  downstream accepts the element this cycle (exp stage ties this to its idle state).
- out_fp32  output  32  FP32 result x[i]−max.
- out_last  output  1  marks the final element of the row on output.
- row_overflow  output  1  one-cycle pulse when a row is truncated at MAX_LEN.

Behaviour:
- Reset is asynchronous and active-low, on clk. Reset values:
  - in_ready=0, out_valid=0, out_fp32=0, out_last=0, row_overflow=0.
  - State=S_LOAD, counters=0, max=0.
  - Adder start=0.
  - Buffer contents are don't-care.
- Reset mid-operation discards the current row entirely. The adder driver is reset from ~rst_n.
- S_LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: write buf[wr_cnt]=in_fp32 and increment wr_cnt.
  - The first element of a row loads max directly. Later elements replace max when fp_gt(in, max).
  - If in_last, or wr_cnt==MAX_LEN−1 on that accept: latch len=wr_cnt+1, go to S_SUB_ISSUE, set in_ready=0 next cycle.
  - If the truncation case fires without in_last: pulse row_overflow for 1 cycle. Any further input is not accepted until the next S_LOAD.
- fp_gt compare:
  - Sign-magnitude ordering; −0 and +0 compare equal.
  - NaN inputs (exp=FF, mant≠0) never update max but are stored and subtracted normally.
  - +Inf becomes max. The result is then NaN for that element and −Inf for finite elements, as the adder produces.
- S_SUB_ISSUE:
  - When the adder is not busy and start is low: a=buf[rd_cnt], b={~max[31],max[30:0]}, assert start.
  - Hold start until busy is seen high, then drop start and go to S_SUB_WAIT.
- S_SUB_WAIT: on adder done, register out_fp32=z, out_last=(rd_cnt==len−1), out_valid=1, go to S_OUT.
- S_OUT:
  - Hold out_valid, out_fp32 and out_last stable until out_ready.
  - On out_valid&&out_ready: clear out_valid.
  - If out_last: reset wr_cnt, rd_cnt and the first flag; go to S_LOAD.
  - Otherwise: rd_cnt++ and go to S_SUB_ISSUE.
- No overlap between rows: a new row is loaded only after the previous row's last output handshake. Minimum one idle cycle between out_last accept and in_ready=1.
- Per-element latency = adder latency + 3 cycles (issue handshake, done capture, output). There is no fixed-latency guarantee; the bench uses handshakes.
- An x−x element always yields +0 (0x00000000) under RNE.

Test Plan:
- Row [1.0,3.0,2.0] (3F800000,40400000,40000000, last on 3rd) with out_ready=1 → outputs C0000000, 00000000, BF800000. out_last only on the 3rd. in_ready=0 throughout output.
- Single-element row 5.0 (40A00000, in_last=1) → one output 00000000 with out_last=1. Then in_ready returns to 1.
- Negative row [−1.0,−4.0] (BF800000,C0800000) → 00000000, C0400000 (−3.0). Row [−0.0,+0.0] → both outputs +0.
- Backpressure on row [2.0,1.0]: hold out_ready=0 for 10 cycles after first out_valid → out_fp32 stays 00000000 and out_valid stays 1. Then 1 → next output BF800000.
- MAX_LEN=4, feed 5 elements [1,2,3,4,9] with no in_last → row_overflow pulses once at the 4th accept. in_ready drops and the 5th element is not accepted. Outputs C0400000, C0000000, BF800000, 00000000 with last on the 4th. Then the 5th element (9.0) is accepted as a new row.
- Assert rst_n=0 asynchronously during S_SUB_WAIT of a 3-element row → out_valid=0 and in_ready=0 immediately. After release: in_ready=1 and a fresh row [7.0] → 00000000, last.
